// File: rtl/seq_scan_ctrl.sv
// Word-level sequencer around a bit-serial Mealy pattern matcher: accepts a word,
// shifts it MSB-first one bit per clock, then reports match count and positions.
module seq_scan_ctrl #(
  parameter int unsigned      DATA_W = 8,
  parameter int unsigned      PAT_W  = 4,
  parameter logic [PAT_W-1:0] PAT    = 4'b1011,
  localparam int unsigned     CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_overlap,
  input  logic              in_keep,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [DATA_W-1:0] match_pos,
  output logic              busy
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned LEN_W = $clog2(PAT_W + 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic              w_accept;
  logic              w_shift_en;

  logic [DATA_W-1:0] r_shift;
  logic              r_overlap;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_match_cnt;
  logic [DATA_W-1:0] r_match_pos;
  logic [PAT_W-1:0]  r_hist;
  logic [LEN_W-1:0]  r_hist_len;

  logic              w_bit;
  logic [PAT_W:0]    w_hist_ext;
  logic [PAT_W-1:0]  w_hist_nxt;
  logic              w_len_full;
  logic [LEN_W-1:0]  w_len_nxt;
  logic              w_match;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift_en  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        w_shift_en = 1'b1;
        if (r_idx == '0) begin
          w_state_nxt = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Matcher step: the incoming bit completes a match only once PAT_W bits are in history
  assign w_bit      = r_shift[DATA_W-1];
  assign w_hist_ext = {r_hist, w_bit};
  assign w_hist_nxt = w_hist_ext[PAT_W-1:0];
  assign w_len_full = (r_hist_len >= LEN_W'(PAT_W - 1));
  assign w_len_nxt  = w_len_full ? LEN_W'(PAT_W) : (r_hist_len + LEN_W'(1));
  assign w_match    = w_len_full && (w_hist_nxt == PAT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shift     <= '0;
      r_overlap   <= 1'b0;
      r_idx       <= '0;
      r_match_cnt <= '0;
      r_match_pos <= '0;
      r_hist      <= '0;
      r_hist_len  <= '0;
    end else if (w_accept) begin
      r_shift     <= in_data;
      r_overlap   <= in_overlap;
      r_idx       <= IDX_W'(DATA_W - 1);
      r_match_cnt <= '0;
      r_match_pos <= '0;
      if (!in_keep) begin
        r_hist     <= '0;
        r_hist_len <= '0;
      end
    end else if (w_shift_en) begin
      r_shift <= r_shift << 1;
      r_idx   <= r_idx - IDX_W'(1);
      r_hist  <= w_hist_nxt;
      if (w_match) begin
        r_match_cnt <= r_match_cnt + CNT_W'(1);
        r_match_pos <= r_match_pos | (DATA_W'(1) << r_idx);
        // Non-overlapping mode needs PAT_W fresh bits before the next match
        r_hist_len  <= r_overlap ? w_len_nxt : '0;
      end else begin
        r_hist_len  <= w_len_nxt;
      end
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_REPORT);
  assign busy      = (r_state != ST_IDLE);
  assign match_cnt = r_match_cnt;
  assign match_pos = r_match_pos;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl: scoreboard of expected word results
// plus per-scenario checks of latency, stalls, reset and throughput.
module tb_seq_scan_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned PAT_W  = 4;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pos;
  } res_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_overlap;
  logic              in_keep;
  logic              out_valid;
  logic              out_ready;
  logic [CNT_W-1:0]  match_cnt;
  logic [DATA_W-1:0] match_pos;
  logic              busy;

  res_t exp_q[$];
  int   acc_cyc[$];
  int   m_bits[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  seq_scan_ctrl #(.DATA_W(DATA_W), .PAT_W(PAT_W), .PAT(4'b1011)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_overlap(in_overlap), .in_keep(in_keep),
    .out_valid(out_valid), .out_ready(out_ready),
    .match_cnt(match_cnt), .match_pos(match_pos), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: samples on the falling edge, ahead of the handshake edge
  always @(negedge clk) begin
    res_t e;
    if (rst === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) acc_cyc.push_back(cyc);
    if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got cnt=%0d pos=%b with empty queue", match_cnt, match_pos);
      end else begin
        e = exp_q.pop_front();
        if ({match_cnt, match_pos} !== e) begin
          failures++;
          $display("FAIL sb_result got cnt=%0d pos=%b want cnt=%0d pos=%b",
                   match_cnt, match_pos, e.cnt, e.pos);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Reference matcher over the bit stream seen since the last clear
  task automatic model_word(input logic [DATA_W-1:0] w, input logic ov, input logic kp,
                            output res_t r);
    r = '0;
    if (!kp) m_bits.delete();
    for (int i = DATA_W - 1; i >= 0; i--) begin
      m_bits.push_back(int'(w[i]));
      if (m_bits.size() > PAT_W) void'(m_bits.pop_front());
      if (m_bits.size() == PAT_W && m_bits[0] == 1 && m_bits[1] == 0 &&
          m_bits[2] == 1 && m_bits[3] == 1) begin
        r.cnt    = r.cnt + CNT_W'(1);
        r.pos[i] = 1'b1;
        if (!ov) m_bits.delete();
      end
    end
  endtask

  // Offers one word and returns #1 after its accept edge
  task automatic send(input logic [DATA_W-1:0] d, input logic ov, input logic kp,
                      input logic exp_out, input res_t e);
    int n = 0;
    while (in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    if (exp_out) exp_q.push_back(e);
    in_data = d; in_overlap = ov; in_keep = kp; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    in_data    = DATA_W'($urandom);
    in_overlap = 1'($urandom);
    in_keep    = 1'($urandom);
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b0; in_data = '0; in_overlap = 1'b0; in_keep = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy, match_cnt, match_pos} !== {3'b100, 4'd0, 8'd0}) begin
      failures++;
      $display("FAIL reset_state got rdy=%b ov=%b busy=%b cnt=%0d pos=%b want 1 0 0 0 0",
               in_ready, out_valid, busy, match_cnt, match_pos);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_overlap();
    int n;
    send(8'b1011_0110, 1'b1, 1'b0, 1'b1, '{cnt: 4'd2, pos: 8'b0001_0010});
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL overlap_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    wait_out(n);
    checks++;
    if (n !== DATA_W) begin
      failures++;
      $display("FAIL overlap_latency got %0d edges want %0d", n, DATA_W);
    end
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL overlap_release got rdy=%b ov=%b want 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_nonoverlap();
    int n;
    send(8'b1011_0110, 1'b0, 1'b0, 1'b1, '{cnt: 4'd1, pos: 8'b0001_0000});
    wait_out(n);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL nonoverlap_timeout got out_valid=%b want 1", out_valid);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_keep();
    int n;
    send(8'b0000_0101, 1'b1, 1'b0, 1'b1, '{cnt: 4'd0, pos: 8'd0});
    wait_out(n);
    @(posedge clk); #1;
    send(8'b1000_0000, 1'b1, 1'b1, 1'b1, '{cnt: 4'd1, pos: 8'b1000_0000});
    wait_out(n);
    checks++;
    if (match_cnt !== 4'd1) begin
      failures++;
      $display("FAIL keep_history got cnt=%0d want 1", match_cnt);
    end
    @(posedge clk); #1;
    send(8'b1000_0000, 1'b1, 1'b0, 1'b1, '{cnt: 4'd0, pos: 8'd0});
    wait_out(n);
    checks++;
    if (match_cnt !== 4'd0 || match_pos !== 8'd0) begin
      failures++;
      $display("FAIL keep_cleared got cnt=%0d pos=%b want 0 0", match_cnt, match_pos);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int n;
    int acc_before;
    res_t held;
    out_ready = 1'b0;
    send(8'b1011_0110, 1'b1, 1'b0, 1'b1, '{cnt: 4'd2, pos: 8'b0001_0010});
    wait_out(n);
    held = {match_cnt, match_pos};
    acc_before = acc_cyc.size();
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; in_data = DATA_W'($urandom); in_keep = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {match_cnt, match_pos} !== held) begin
        failures++;
        $display("FAIL stall_hold cyc%0d got ov=%b rdy=%b cnt=%0d pos=%b want 1 0 %0d %b",
                 k, out_valid, in_ready, match_cnt, match_pos, held.cnt, held.pos);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (acc_cyc.size() !== acc_before) begin
      failures++;
      $display("FAIL stall_accept got %0d accepts want 0", acc_cyc.size() - acc_before);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL stall_release got rdy=%b ov=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(8'b1011_0110, 1'b1, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, match_cnt, match_pos} !== {3'b100, 4'd0, 8'd0}) begin
      failures++;
      $display("FAIL midreset_state got rdy=%b ov=%b busy=%b cnt=%0d pos=%b want 1 0 0 0 0",
               in_ready, out_valid, busy, match_cnt, match_pos);
    end
    in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_noaccept got busy=%b rdy=%b want 0 1", busy, in_ready);
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    send(8'b1011_1011, 1'b1, 1'b0, 1'b1, '{cnt: 4'd2, pos: 8'b0001_0001});
    wait_out(n);
    checks++;
    if (n !== DATA_W) begin
      failures++;
      $display("FAIL midreset_latency got %0d edges want %0d", n, DATA_W);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int   n;
    res_t e;
    logic [DATA_W-1:0] w;
    logic ov, kp;
    acc_cyc.delete();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      w  = (k == 0) ? 8'b1011_1011 : DATA_W'($urandom);
      ov = (k == 0) ? 1'b1 : 1'($urandom);
      kp = (k == 0) ? 1'b0 : 1'($urandom);
      n = 0;
      while (in_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
      model_word(w, ov, kp, e);
      exp_q.push_back(e);
      in_data = w; in_overlap = ov; in_keep = kp; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (exp_q.size() != 0 || acc_cyc.size() != 6) begin
      failures++;
      $display("FAIL b2b_drain got pending=%0d accepts=%0d want 0 6", exp_q.size(), acc_cyc.size());
    end
    for (int k = 1; k < acc_cyc.size(); k++) begin
      checks++;
      if (acc_cyc[k] - acc_cyc[k-1] !== DATA_W + 2) begin
        failures++;
        $display("FAIL b2b_spacing word%0d got %0d cycles want %0d",
                 k, acc_cyc[k] - acc_cyc[k-1], DATA_W + 2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_overlap();
    test_nonoverlap();
    test_keep();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got %0d pending results want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
